// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: FSM encoding,
// halt encoding, PC stride and default memory geometry.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_HALTED = 2'd1,
      ST_ERROR  = 2'd2
   } fetch_state_e;

   localparam logic [15:0] HALT_INSTR_DEF = 16'hEFFF;
   localparam logic [15:0] PC_STEP        = 16'd2;
   localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
   localparam int          IM_DEPTH_DEF   = 100;

endpackage

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch controller: issues addresses to a registered-read
// instruction memory and offers the returned words to decode (valid/ready).
module im_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
   parameter int          IM_DEPTH   = IM_DEPTH_DEF,
   parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] im_addr,
   input  logic [15:0] im_inst,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [15:0] id_inst,
   output logic [15:0] id_pc,
   input  logic        br_valid,
   input  logic [15:0] br_target,
   input  logic        restart,
   output logic        halted,
   output logic        err,
   output logic [15:0] retired_cnt
);

   localparam logic [16:0] DEPTH_LIM = 17'(IM_DEPTH);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  req_pc_q, req_pc_d;
   logic         req_vld_q, req_vld_d;
   logic [15:0]  retired_q, retired_d;

   logic stall;
   logic transfer;
   logic pc_bad;

   assign id_valid    = req_vld_q && (state_q == ST_FETCH);
   assign id_inst     = im_inst;
   assign id_pc       = req_pc_q;
   assign halted      = (state_q == ST_HALTED);
   assign err         = (state_q == ST_ERROR);
   assign retired_cnt = retired_q;

   assign stall    = id_valid && !id_ready;
   assign transfer = id_valid && id_ready;
   assign pc_bad   = ({1'b0, pc_q} >= DEPTH_LIM) || pc_q[0];

   // Under stall the memory re-reads the offered word so id_inst stays put.
   assign im_addr = stall ? req_pc_q : pc_q;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned
      // (that would infer a latch); the branches below only override.
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      req_vld_d = req_vld_q;
      retired_d = retired_q + 16'(transfer);

      if (restart) begin
         state_d   = ST_FETCH;
         pc_d      = RESET_PC;
         req_vld_d = 1'b0;
      end else if (state_q == ST_FETCH) begin
         if (br_valid) begin
            pc_d      = br_target;
            req_vld_d = 1'b0;
         end else if (transfer && (im_inst == HALT_INSTR)) begin
            state_d   = ST_HALTED;
            req_vld_d = 1'b0;
         end else if (!stall) begin
            if (pc_bad) begin
               state_d   = ST_ERROR;
               req_vld_d = 1'b0;
            end else begin
               req_pc_d  = pc_q;
               req_vld_d = 1'b1;
               pc_d      = pc_q + PC_STEP;
            end
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         req_pc_q  <= 16'h0000;
         req_vld_q <= 1'b0;
         retired_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         req_vld_q <= req_vld_d;
         retired_q <= retired_d;
      end
   end

endmodule
